// File: rtl/wash_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// wash_cycle_ctrl
//
// Washing-machine phase sequencer:
//   FILL -> WASH -> RINSE [-> WASH -> RINSE]*passes -> SPIN -> DONE
//
// Phase lengths are given in seconds. A prescaler turns clock cycles into
// one-second ticks. The number of cycles per second is SEC_DIV << clk_freq,
// and it is captured when a cycle starts. The number of extra wash/rinse
// passes is also captured at start, clamped to MAX_EXTRA.
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   clk_freq      clock-rate select, captured on start
//   coin_in       start request (level), honoured only in IDLE/DONE
//   extra_washes  extra wash+rinse passes, captured on start
//   timer_pause   freezes the sequencer while high (busy phases only)
//   abort         cancels the cycle; wins over pause and coin_in
//   busy          high in FILL/WASH/RINSE/SPIN
//   wash_done     high while in DONE
//   phase         0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 DONE
//   sec_left      whole seconds left in the current phase, 0 in IDLE/DONE
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module wash_cycle_ctrl #(
  parameter int SEC_DIV   = 1_000_000,
  parameter int FILL_S    = 120,
  parameter int WASH_S    = 300,
  parameter int RINSE_S   = 120,
  parameter int SPIN_S    = 60,
  parameter int MAX_EXTRA = 3,
  parameter int TIME_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        clk_freq,
  input  logic              coin_in,
  input  logic [1:0]        extra_washes,
  input  logic              timer_pause,
  input  logic              abort,
  output logic              busy,
  output logic              wash_done,
  output logic [2:0]        phase,
  output logic [TIME_W-1:0] sec_left
);

  // The largest divider is SEC_DIV*8. The prescaler only has to reach
  // divider-1, so $clog2(SEC_DIV*8) bits always suffice. Storing divider-1
  // rather than the divider keeps that register the same width.
  localparam int PRE_W = $clog2(SEC_DIV * 8);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_WASH  = 3'd2;
  localparam logic [2:0] ST_RINSE = 3'd3;
  localparam logic [2:0] ST_SPIN  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [TIME_W-1:0] FILL_T  = TIME_W'(FILL_S);
  localparam logic [TIME_W-1:0] WASH_T  = TIME_W'(WASH_S);
  localparam logic [TIME_W-1:0] RINSE_T = TIME_W'(RINSE_S);
  localparam logic [TIME_W-1:0] SPIN_T  = TIME_W'(SPIN_S);

  // The pass counter is as wide as extra_washes, so any clamp above 3 is moot.
  localparam logic [1:0] MAX_PASS = (MAX_EXTRA > 3) ? 2'd3 : 2'(MAX_EXTRA);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]        state_reg,  state_next;
  logic [PRE_W-1:0]  pre_reg,    pre_next;
  logic [TIME_W-1:0] sec_reg,    sec_next;
  logic [1:0]        pass_reg,   pass_next;
  logic [PRE_W-1:0]  div_m1_reg, div_m1_next;
  logic              busy_reg,   busy_next;
  logic              done_reg,   done_next;

  logic              tick;

  // ---------------------------------------------------------------------------
  // Divider table: one terminal count (divider-1) per clk_freq setting.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] div_tab [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_div
      assign div_tab[gi] = PRE_W'((SEC_DIV << gi) - 1);
    end
  endgenerate

  // Seconds to load when a phase is entered. DONE and IDLE show zero.
  function automatic logic [TIME_W-1:0] phase_len(input logic [2:0] st);
    logic [TIME_W-1:0] len;
    len = '0;
    case (st)
      ST_FILL:  len = FILL_T;
      ST_WASH:  len = WASH_T;
      ST_RINSE: len = RINSE_T;
      ST_SPIN:  len = SPIN_T;
      default:  len = '0;
    endcase
    return len;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    pre_next    = pre_reg;
    sec_next    = sec_reg;
    pass_next   = pass_reg;
    div_m1_next = div_m1_reg;
    tick        = (pre_reg == div_m1_reg);

    if (abort) begin
      // Abort wins over everything, including pause and a pending coin.
      state_next  = ST_IDLE;
      pre_next    = '0;
      sec_next    = '0;
      pass_next   = '0;
      div_m1_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // Pause has no effect here, so a start is still accepted.
          if (coin_in) begin
            state_next  = ST_FILL;
            pre_next    = '0;
            sec_next    = FILL_T;
            div_m1_next = div_tab[clk_freq];
            pass_next   = (extra_washes > MAX_PASS) ? MAX_PASS : extra_washes;
          end
        end

        ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
          // A paused cycle changes nothing. That includes the cycle that
          // would have produced a tick, so the tick simply moves later.
          if (!timer_pause) begin
            if (!tick) begin
              pre_next = pre_reg + PRE_W'(1);
            end else begin
              pre_next = '0;
              if (sec_reg > TIME_W'(1)) begin
                sec_next = sec_reg - TIME_W'(1);
              end else begin
                // The last second of the phase has expired. The next phase
                // and its full duration load on this same edge, so every
                // phase lasts exactly seconds*divider unpaused cycles.
                case (state_reg)
                  ST_FILL: state_next = ST_WASH;
                  ST_WASH: state_next = ST_RINSE;
                  ST_RINSE: begin
                    if (pass_reg != 2'd0) begin
                      state_next = ST_WASH;
                      pass_next  = pass_reg - 2'd1;
                    end else begin
                      state_next = ST_SPIN;
                    end
                  end
                  default: state_next = ST_DONE;
                endcase
                sec_next = phase_len(state_next);
              end
            end
          end
        end

        default: begin
          // Unused encodings fall back to a clean idle.
          state_next  = ST_IDLE;
          pre_next    = '0;
          sec_next    = '0;
          pass_next   = '0;
          div_m1_next = '0;
        end
      endcase
    end

    // Status flags are decoded from the next state so that they stay
    // registered and line up with phase.
    busy_next = (state_next == ST_FILL)  || (state_next == ST_WASH) ||
                (state_next == ST_RINSE) || (state_next == ST_SPIN);
    done_next = (state_next == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      pre_reg    <= '0;
      sec_reg    <= '0;
      pass_reg   <= '0;
      div_m1_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pre_reg    <= pre_next;
      sec_reg    <= sec_next;
      pass_reg   <= pass_next;
      div_m1_reg <= div_m1_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign busy      = busy_reg;
  assign wash_done = done_reg;
  assign phase     = state_reg;
  assign sec_left  = sec_reg;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wash_cycle_ctrl
//
// Directed test bench for wash_cycle_ctrl with a small divider
// (SEC_DIV=4, FILL=3 s, WASH=5 s, RINSE=3 s, SPIN=2 s).
// With clk_freq=0 the phases last 12/20/12/8 cycles.
// All expected values are hand-computed edge offsets from the start edge E0.
// Inputs are driven on the falling edge, and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_wash_cycle_ctrl;

  localparam int TIME_W = 16;

  logic              clk;
  logic              rst_n;
  logic [1:0]        clk_freq;
  logic              coin_in;
  logic [1:0]        extra_washes;
  logic              timer_pause;
  logic              abort;
  logic              busy;
  logic              wash_done;
  logic [2:0]        phase;
  logic [TIME_W-1:0] sec_left;

  int total;
  int bad;
  int edge_cnt;
  int e0;

  wash_cycle_ctrl #(
    .SEC_DIV   (4),
    .FILL_S    (3),
    .WASH_S    (5),
    .RINSE_S   (3),
    .SPIN_S    (2),
    .MAX_EXTRA (3),
    .TIME_W    (TIME_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_freq     (clk_freq),
    .coin_in      (coin_in),
    .extra_washes (extra_washes),
    .timer_pause  (timer_pause),
    .abort        (abort),
    .busy         (busy),
    .wash_done    (wash_done),
    .phase        (phase),
    .sec_left     (sec_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Every comparison goes through this task.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("check %s got=%0d exp=%0d ok", tag, got, exp);
    end
  endtask

  // Move forward to the falling edge that follows start-relative edge 'off'.
  task automatic goto(input int off);
    while (edge_cnt - e0 < off) @(negedge clk);
  endtask

  // Present coin for one edge (E0). Return at the falling edge after E0.
  task automatic start_cycle(input logic [1:0] f, input logic [1:0] x);
    @(negedge clk);
    clk_freq     = f;
    extra_washes = x;
    coin_in      = 1'b1;
    @(negedge clk);
    coin_in = 1'b0;
    e0      = edge_cnt;
  endtask

  // Bounded wait for wash_done. Record the edge offset at which it rose.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (wash_done === 1'b1) begin
        lat = edge_cnt - e0;
        break;
      end
    end
    check_val(tag, lat, exp_lat);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    e0           = 0;
    rst_n        = 1'b0;
    clk_freq     = 2'd0;
    coin_in      = 1'b0;
    extra_washes = 2'd0;
    timer_pause  = 1'b0;
    abort        = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check_val("rst_phase", phase, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", wash_done, 0);
    check_val("rst_sec", sec_left, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle_hold", phase, 0);

    // ---- 1: basic cycle, 12/20/12/8 ----
    start_cycle(2'd0, 2'd0);
    check_val("t1_e0_phase", phase, 1);
    check_val("t1_e0_sec", sec_left, 3);
    check_val("t1_e0_busy", busy, 1);
    goto(3);  check_val("t1_e3_sec", sec_left, 3);
    goto(4);  check_val("t1_e4_sec", sec_left, 2);
    goto(11); check_val("t1_e11_phase", phase, 1);
    check_val("t1_e11_sec", sec_left, 1);
    goto(12); check_val("t1_e12_phase", phase, 2);
    check_val("t1_e12_sec", sec_left, 5);
    // A coin while busy must be ignored.
    goto(19); coin_in = 1'b1;
    @(negedge clk); coin_in = 1'b0;
    check_val("t1_coin_busy_phase", phase, 2);
    check_val("t1_coin_busy_sec", sec_left, 3);
    goto(32); check_val("t1_e32_phase", phase, 3);
    check_val("t1_e32_sec", sec_left, 3);
    goto(44); check_val("t1_e44_phase", phase, 4);
    goto(51); check_val("t1_e51_phase", phase, 4);
    check_val("t1_e51_sec", sec_left, 1);
    wait_done("t1_done_lat", 52);
    check_val("t1_done_phase", phase, 5);
    check_val("t1_done_busy", busy, 0);
    check_val("t1_done_sec", sec_left, 0);
    goto(60); check_val("t1_done_held", wash_done, 1);

    // ---- 2: extra passes (start from DONE) ----
    start_cycle(2'd0, 2'd1);
    check_val("t2_restart_done", wash_done, 0);
    check_val("t2_restart_phase", phase, 1);
    goto(44); check_val("t2_wash2_phase", phase, 2);
    goto(64); check_val("t2_rinse2_phase", phase, 3);
    goto(76); check_val("t2_spin_phase", phase, 4);
    wait_done("t2_x1_done_lat", 84);
    start_cycle(2'd0, 2'd3);
    wait_done("t2_x3_done_lat", 148);

    // ---- 3: clock-rate select and mid-cycle changes ----
    start_cycle(2'd1, 2'd0);
    goto(8); check_val("t3_f1_e8_sec", sec_left, 2);
    wait_done("t3_f1_done_lat", 104);
    start_cycle(2'd1, 2'd0);
    goto(10);
    clk_freq     = 2'd3;
    extra_washes = 2'd3;
    wait_done("t3_change_done_lat", 104);
    clk_freq     = 2'd0;
    extra_washes = 2'd0;

    // ---- 4: pause inside WASH, then again across a tick ----
    start_cycle(2'd0, 2'd0);
    goto(14); timer_pause = 1'b1;       // edges 15..21 frozen
    goto(18); check_val("t4_pause_sec", sec_left, 5);
    check_val("t4_pause_phase", phase, 2);
    goto(21); timer_pause = 1'b0;
    goto(23); check_val("t4_resume_tick", sec_left, 4);
    goto(26); timer_pause = 1'b1;       // edge 27 was a tick edge
    goto(29); timer_pause = 1'b0;
    check_val("t4_tick_blocked", sec_left, 4);
    goto(30); check_val("t4_tick_late", sec_left, 3);
    wait_done("t4_done_lat", 62);

    // ---- 5: start with pause high in DONE, then abort in RINSE ----
    timer_pause = 1'b1;
    start_cycle(2'd0, 2'd0);
    check_val("t5_start_paused", phase, 1);
    goto(2); timer_pause = 1'b0;
    check_val("t5_frozen_sec", sec_left, 3);
    goto(40); check_val("t5_rinse_phase", phase, 3);
    check_val("t5_rinse_sec", sec_left, 2);
    abort       = 1'b1;
    timer_pause = 1'b1;
    coin_in     = 1'b1;
    @(negedge clk);
    abort       = 1'b0;
    timer_pause = 1'b0;
    coin_in     = 1'b0;
    check_val("t5_abort_phase", phase, 0);
    check_val("t5_abort_busy", busy, 0);
    check_val("t5_abort_done", wash_done, 0);
    check_val("t5_abort_sec", sec_left, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("t5_abort_idle", phase, 0);
    repeat (3) @(negedge clk);
    check_val("t5_no_done_pulse", wash_done, 0);

    // ---- 6: asynchronous reset in SPIN ----
    start_cycle(2'd0, 2'd0);
    goto(46); check_val("t6_spin_phase", phase, 4);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_phase", phase, 0);
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_sec", sec_left, 0);
    check_val("t6_rst_done", wash_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_val("t6_post_phase", phase, 0);
    check_val("t6_post_busy", busy, 0);
    start_cycle(2'd0, 2'd0);
    check_val("t6_restart_phase", phase, 1);
    check_val("t6_restart_sec", sec_left, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
